// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - opcode constants, state and op-class types for the multi-cycle sequencer
package ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_HALT, ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_OP, CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYSTEM
    } opclass_t;

    function automatic logic writes_rd(input opclass_t cls);
        return !(cls == CLS_STORE || cls == CLS_BRANCH || cls == CLS_SYSTEM);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opclass_dec.sv
// rtl/multicycle_ctrl_opclass_dec.sv - combinational opcode to op-class decode with illegal/ebreak flags
module opclass_dec
    import ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [11:0] imm12,
    output opclass_t    cls,
    output logic        illegal,
    output logic        ebreak
);

    always_comb begin
        cls     = CLS_OP;
        illegal = 1'b0;
        ebreak  = 1'b0;
        case (opcode)
            OPC_OP:     cls = CLS_OP;
            OPC_OPIMM:  cls = CLS_OPIMM;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_SYSTEM: begin
                cls    = CLS_SYSTEM;
                ebreak = (imm12 == 12'h001);
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle sequencer (IF/ID/EX/MEM/WB); MULTICYCLE_PERF_EN adds cycle/instret counters
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    input  logic [31:0] target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        halt,
    output logic        trap
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
`endif
);

    state_t      state, state_nxt;
    logic [31:0] pc_q, inst_q, next_pc;
    opclass_t    cls_q, dec_cls;
    logic        dec_illegal, dec_ebreak;
    logic [15:0] wait_cnt;
    logic [16:0] wait_inc;
    logic        wait_hit, redirect, misaligned;

    opclass_dec u_dec (
        .opcode  (opcode),
        .imm12   (inst_q[31:20]),
        .cls     (dec_cls),
        .illegal (dec_illegal),
        .ebreak  (dec_ebreak)
    );

    // wait_hit means this cycle is the TIMEOUT-th without ack; an ack in it still wins
    assign wait_inc = {1'b0, wait_cnt} + 17'd1;
    assign wait_hit = (wait_inc == 17'(TIMEOUT));

    always_comb begin
        next_pc  = pc_q + 32'd4;
        redirect = 1'b0;
        case (cls_q)
            CLS_JAL: begin
                next_pc  = target;
                redirect = 1'b1;
            end
            CLS_JALR: begin
                next_pc  = {target[31:1], 1'b0};
                redirect = 1'b1;
            end
            CLS_BRANCH: begin
                if (br_taken) begin
                    next_pc  = target;
                    redirect = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign misaligned = redirect && (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IF;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IF: begin
                if (imem_ack)      state_nxt = ST_ID;
                else if (wait_hit) state_nxt = ST_TRAP;
            end
            ST_ID: begin
                if (dec_illegal)     state_nxt = ST_TRAP;
                else if (dec_ebreak) state_nxt = ST_HALT;
                else                 state_nxt = ST_EX;
            end
            ST_EX:  state_nxt = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack)      state_nxt = ST_WB;
                else if (wait_hit) state_nxt = ST_TRAP;
            end
            ST_WB:   state_nxt = misaligned ? ST_TRAP : ST_IF;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        imem_req = (state == ST_IF);
        dmem_req = (state == ST_MEM);
        dmem_we  = (state == ST_MEM) && (cls_q == CLS_STORE);
        rf_we    = (state == ST_WB) && writes_rd(cls_q) && !misaligned;
        halt     = (state == ST_HALT);
        trap     = (state == ST_TRAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            cls_q    <= CLS_OP;
            wait_cnt <= '0;
        end else begin
            if (state == ST_IF && imem_ack) inst_q <= imem_rdata;
            if (state == ST_ID)             cls_q  <= dec_cls;
            if (state == ST_WB && !misaligned) pc_q <= next_pc;
            // only IF and MEM wait; leaving either clears the count for the next entry
            if ((state == ST_IF && !imem_ack) || (state == ST_MEM && !dmem_ack))
                wait_cnt <= wait_inc[15:0];
            else
                wait_cnt <= '0;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign inst      = inst_q;

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else begin
            if (state != ST_HALT && state != ST_TRAP)
                perf_cycle <= perf_cycle + 64'd1;
            if (state == ST_WB || (state == ST_ID && state_nxt == ST_HALT))
                perf_instret <= perf_instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl with a per-instruction latency model
module tb_multicycle_ctrl;

    localparam int          TO  = 4;
    localparam logic [31:0] RPC = 32'h8000_0000;

    localparam logic [6:0] O_OP = 7'b0110011, O_OPI = 7'b0010011, O_LD = 7'b0000011,
                           O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                           O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUI = 7'b0010111,
                           O_SYS = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, inst, target = '0, pc;
    logic [6:0]  opcode;
    logic        br_taken = 1'b0, dmem_req, dmem_we, dmem_ack = 1'b0, rf_we, halt, trap;

    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .opcode(opcode),
        .br_taken(br_taken), .target(target), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .rf_we(rf_we), .pc(pc), .halt(halt), .trap(trap)
    );

    // stand-in decoder
    assign opcode = inst[6:0];

    typedef struct packed {
        logic        imem_req, dmem_req, dmem_we, rf_we, halt, trap;
        logic [31:0] pc, inst;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0, fails = 0;
    logic [31:0] m_pc = RPC, m_inst = 32'h13;
    logic        m_halt = 1'b0, m_trap = 1'b0;

    function automatic exp_t mk(input logic ireq, input logic dreq, input logic dwe, input logic rfwe);
        exp_t e;
        e = '{ireq, dreq, dwe, rfwe, m_halt, m_trap, m_pc, m_inst};
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = '{imem_req, dmem_req, dmem_we, rf_we, halt, trap, pc, inst};
            tests++;
            if (a !== e || imem_addr !== e.pc) begin
                fails++;
                $display("FAIL cycle@%0t got ireq=%b dreq=%b we=%b rf=%b h=%b t=%b pc=%h addr=%h inst=%h want ireq=%b dreq=%b we=%b rf=%b h=%b t=%b pc=%h inst=%h",
                         $time, a.imem_req, a.dmem_req, a.dmem_we, a.rf_we, a.halt, a.trap, a.pc, imem_addr, a.inst,
                         e.imem_req, e.dmem_req, e.dmem_we, e.rf_we, e.halt, e.trap, e.pc, e.inst);
            end
        end
    end

    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = RPC; m_inst = 32'h13; m_halt = 1'b0; m_trap = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] w, input int iw, output bit ok);
        ok = 1'b0;
        imem_rdata = w;
        for (int k = 0; k < 1000; k++) begin
            imem_ack = (k == iw);
            cyc(mk(1, 0, 0, 0));
            if (k == iw) begin ok = 1'b1; break; end
            if (k + 1 == TO) break;
        end
        imem_ack = 1'b0;
        if (ok) m_inst = w;
        else    m_trap = 1'b1;
    endtask

    task automatic exec(input logic [31:0] w, input int iw, input int dw, input bit taken,
                        input logic [31:0] tgt, output int ncyc);
        bit          ok, wr, legal, redirect, is_mem;
        logic [6:0]  op;
        logic [31:0] npc;
        ncyc = 0; target = tgt; br_taken = taken;
        fetch(w, iw, ok);
        if (!ok) return;
        ncyc  = iw + 1;
        op    = w[6:0];
        wr    = op inside {O_OP, O_OPI, O_LUI, O_AUI, O_JAL, O_JALR, O_LD};
        legal = wr || (op inside {O_ST, O_BR, O_SYS});
        is_mem = (op == O_LD) || (op == O_ST);
        cyc(mk(0, 0, 0, 0)); ncyc++;
        if (!legal) begin m_trap = 1'b1; return; end
        if (op == O_SYS && w[31:20] == 12'h001) begin m_halt = 1'b1; return; end
        cyc(mk(0, 0, 0, 0)); ncyc++;
        if (is_mem) begin
            for (int k = 0; k < 1000; k++) begin
                dmem_ack = (k == dw);
                cyc(mk(0, 1, op == O_ST, 0)); ncyc++;
                if (k == dw) break;
                if (k + 1 == TO) begin dmem_ack = 1'b0; m_trap = 1'b1; return; end
            end
            dmem_ack = 1'b0;
        end
        npc = m_pc + 32'd4; redirect = 1'b0;
        if (op == O_JAL)            begin npc = tgt; redirect = 1'b1; end
        if (op == O_JALR)           begin npc = tgt & ~32'd1; redirect = 1'b1; end
        if (op == O_BR && taken)    begin npc = tgt; redirect = 1'b1; end
        if (redirect && npc[1:0] != 2'b00) begin
            cyc(mk(0, 0, 0, 0)); ncyc++;
            m_trap = 1'b1;
            return;
        end
        cyc(mk(0, 0, 0, wr)); ncyc++;
        m_pc = npc;
    endtask

    // terminal states must ignore stray acks
    task automatic terminal(input int n);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        repeat (n) cyc(mk(0, 0, 0, 0));
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    initial begin
        int n;
        bit ok;
        repeat (2) @(posedge clk);
        #1;
        reset_dut();
        chk("reset_imem_req", {31'd0, imem_req}, 32'd1);
        chk("reset_pc", pc, 32'h8000_0000);
        chk("reset_inst", inst, 32'h0000_0013);
        chk("reset_strobes", {28'd0, dmem_req, dmem_we, rf_we, halt | trap}, 32'd0);

        exec(32'h0010_0093, 0, 0, 0, 0, n);  chk("addi_cycles", n, 4);
        chk("addi_pc", pc, 32'h8000_0004);
        exec(32'h0000_2103, 3, 2, 0, 0, n);  chk("load_cycles", n, 10);
        chk("load_pc", pc, 32'h8000_0008);
        exec(32'h0011_2023, 0, 0, 0, 0, n);  chk("store_cycles", n, 5);
        exec(32'h0080_00ef, 0, 0, 0, 32'hFFFF_FFFC, n);
        chk("jal_far_pc", pc, 32'hFFFF_FFFC);
        exec(32'h0010_0093, 1, 0, 0, 0, n);  chk("pc_wrap", pc, 32'h0000_0000);
        exec(32'h0000_0063, 0, 0, 1, 32'h8000_0040, n);  chk("beq_taken_pc", pc, 32'h8000_0040);
        exec(32'h0000_0063, 0, 0, 0, 32'h8000_0400, n);  chk("beq_nt_pc", pc, 32'h8000_0044);
        exec(32'h0000_00e7, 0, 0, 0, 32'h8000_0101, n);  chk("jalr_pc", pc, 32'h8000_0100);
        exec(32'h1234_50b7, 0, 0, 0, 0, n);
        exec(32'h0000_0097, 0, 0, 0, 0, n);
        exec(32'h0020_81b3, 0, 0, 0, 0, n);
        exec(32'h0000_0073, 0, 0, 0, 0, n);  chk("ecall_cycles", n, 4);
        chk("ecall_pc", pc, 32'h8000_0110);
        exec(32'h0080_00ef, 0, 0, 0, 32'h8000_0102, n);
        terminal(2);
        chk("misaligned_trap", {31'd0, trap}, 32'd1);
        chk("misaligned_pc", pc, 32'h8000_0110);

        reset_dut();
        exec(32'h0000_007f, 0, 0, 0, 0, n);
        terminal(2);
        chk("illegal_trap", {31'd0, trap}, 32'd1);

        reset_dut();
        exec(32'h0010_0073, 0, 0, 0, 0, n);
        terminal(3);
        chk("ebreak_halt", {31'd0, halt}, 32'd1);
        chk("ebreak_imem_req", {31'd0, imem_req}, 32'd0);

        reset_dut();
        fetch(32'h0010_0093, 100, ok);
        terminal(2);
        chk("imem_timeout_trap", {31'd0, trap}, 32'd1);

        reset_dut();
        exec(32'h0010_0093, TO - 1, 0, 0, 0, n);
        chk("ack_on_timeout_pc", pc, 32'h8000_0004);
        exec(32'h0000_2103, 0, TO - 1, 0, 0, n);
        chk("dmem_ack_on_timeout_pc", pc, 32'h8000_0008);
        exec(32'h0000_2103, 0, 100, 0, 0, n);
        terminal(2);
        chk("dmem_timeout_trap", {31'd0, trap}, 32'd1);

        reset_dut();
        fetch(32'h0000_2103, 0, ok);
        cyc(mk(0, 0, 0, 0));
        cyc(mk(0, 0, 0, 0));
        cyc(mk(0, 1, 0, 0));
        chk("mem_before_rst", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = RPC; m_inst = 32'h13; m_halt = 1'b0; m_trap = 1'b0;
        chk("rst_mem_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mem_pc", pc, RPC);
        chk("rst_mem_imem_req", {31'd0, imem_req}, 32'd1);
        chk("rst_mem_rf_we", {31'd0, rf_we}, 32'd0);
        exec(32'h0010_0093, 0, 0, 0, 0, n);
        chk("after_rst_pc", pc, 32'h8000_0004);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
